// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared types and constants for the L1 cache controller
// Contents: controller state encoding and datapath address-mux select codes.
package cache_types;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      FETCH
   } cache_state_t;

   localparam logic [1:0] ADDR_CPU  = 2'd0;
   localparam logic [1:0] ADDR_WAY0 = 2'd1;
   localparam logic [1:0] ADDR_WAY1 = 2'd2;
   localparam logic [1:0] ADDR_NEXT = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
// Ports: clk, rst (sync, active-high), inc (count one event), count (holds at all-ones).
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - control FSM for the 2-way write-back, write-allocate L1 cache
// Ports: CPU request/response (mem_read, mem_write, mem_resp), physical-memory handshake
// (pmem_read, pmem_write, pmem_resp), array status (hit*, valid*_out, dirty*_out, lru_out),
// array write strobes and data (load_*, *_in), datapath mux selects, hit/miss counters.
module cache_control
   import cache_types::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   input  logic             hit0,
   input  logic             hit1,
   input  logic             valid0_out,
   input  logic             valid1_out,
   input  logic             dirty0_out,
   input  logic             dirty1_out,
   input  logic             lru_out,
   output logic             load_data0,
   output logic             load_data1,
   output logic             load_tag0,
   output logic             load_tag1,
   output logic             load_valid0,
   output logic             load_valid1,
   output logic             load_dirty0,
   output logic             load_dirty1,
   output logic             load_lru,
   output logic             valid0_in,
   output logic             valid1_in,
   output logic             dirty0_in,
   output logic             dirty1_in,
   output logic             lru_in,
   output logic             datamux_sel,
   output logic [1:0]       addrmux_sel,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   cache_state_t state, next_state;

   logic req;
   logic hit;
   logic victim_dirty;
   logic hit_inc;
   logic miss_inc;

   assign req = mem_read | mem_write;
   assign hit = hit0 | hit1;
   // lru is only rewritten on a hit, so lru_out names the same victim for the whole miss.
   assign victim_dirty = lru_out ? (valid1_out & dirty1_out) : (valid0_out & dirty0_out);

   assign hit_inc  = (state == IDLE) && req && hit;
   assign miss_inc = (state == IDLE) && req && !hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      mem_resp    = 1'b0;
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
      load_data0  = 1'b0;
      load_data1  = 1'b0;
      load_tag0   = 1'b0;
      load_tag1   = 1'b0;
      load_valid0 = 1'b0;
      load_valid1 = 1'b0;
      load_dirty0 = 1'b0;
      load_dirty1 = 1'b0;
      load_lru    = 1'b0;
      valid0_in   = 1'b0;
      valid1_in   = 1'b0;
      dirty0_in   = 1'b0;
      dirty1_in   = 1'b0;
      lru_in      = 1'b0;
      datamux_sel = 1'b0;
      addrmux_sel = ADDR_CPU;

      case (state)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  mem_resp = 1'b1;
                  load_lru = 1'b1;
                  lru_in   = hit0;  // next victim is the way not just used
                  if (mem_write) begin
                     datamux_sel = 1'b1;
                     if (hit0) begin
                        load_data0  = 1'b1;
                        load_dirty0 = 1'b1;
                        dirty0_in   = 1'b1;
                     end else begin
                        load_data1  = 1'b1;
                        load_dirty1 = 1'b1;
                        dirty1_in   = 1'b1;
                     end
                  end
               end else begin
                  next_state = victim_dirty ? WRITEBACK : FETCH;
               end
            end
         end
         WRITEBACK: begin
            pmem_write  = 1'b1;
            addrmux_sel = lru_out ? ADDR_WAY1 : ADDR_WAY0;
            if (pmem_resp) begin
               next_state = FETCH;
            end
         end
         FETCH: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               // Install the fill as clean; a pending write merges on the following hit cycle.
               if (lru_out) begin
                  load_data1  = 1'b1;
                  load_tag1   = 1'b1;
                  load_valid1 = 1'b1;
                  load_dirty1 = 1'b1;
                  valid1_in   = 1'b1;
               end else begin
                  load_data0  = 1'b1;
                  load_tag0   = 1'b1;
                  load_valid0 = 1'b1;
                  load_dirty0 = 1'b1;
                  valid0_in   = 1'b1;
               end
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   sat_counter #(.W(CNT_W)) u_hit_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (hit_count)
   );

   sat_counter #(.W(CNT_W)) u_miss_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (miss_count)
   );

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - scoreboard testbench for cache_control
module tb_cache_control;

   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst;
   logic mem_read, mem_write, mem_resp;
   logic pmem_read, pmem_write, pmem_resp;
   logic hit0, hit1, valid0_out, valid1_out, dirty0_out, dirty1_out, lru_out;
   logic load_data0, load_data1, load_tag0, load_tag1;
   logic load_valid0, load_valid1, load_dirty0, load_dirty1, load_lru;
   logic valid0_in, valid1_in, dirty0_in, dirty1_in, lru_in;
   logic datamux_sel;
   logic [1:0] addrmux_sel;
   logic [CNT_W-1:0] hit_count, miss_count;

   always #5 clk = ~clk;

   cache_control #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_resp    (mem_resp),
      .pmem_read   (pmem_read),
      .pmem_write  (pmem_write),
      .pmem_resp   (pmem_resp),
      .hit0        (hit0),
      .hit1        (hit1),
      .valid0_out  (valid0_out),
      .valid1_out  (valid1_out),
      .dirty0_out  (dirty0_out),
      .dirty1_out  (dirty1_out),
      .lru_out     (lru_out),
      .load_data0  (load_data0),
      .load_data1  (load_data1),
      .load_tag0   (load_tag0),
      .load_tag1   (load_tag1),
      .load_valid0 (load_valid0),
      .load_valid1 (load_valid1),
      .load_dirty0 (load_dirty0),
      .load_dirty1 (load_dirty1),
      .load_lru    (load_lru),
      .valid0_in   (valid0_in),
      .valid1_in   (valid1_in),
      .dirty0_in   (dirty0_in),
      .dirty1_in   (dirty1_in),
      .lru_in      (lru_in),
      .datamux_sel (datamux_sel),
      .addrmux_sel (addrmux_sel),
      .hit_count   (hit_count),
      .miss_count  (miss_count)
   );

   // Output vector bit positions.
   localparam logic [19:0] RESP = 20'd1 << 0;
   localparam logic [19:0] PRD  = 20'd1 << 1;
   localparam logic [19:0] PWR  = 20'd1 << 2;
   localparam logic [19:0] LD0  = 20'd1 << 3;
   localparam logic [19:0] LD1  = 20'd1 << 4;
   localparam logic [19:0] LT0  = 20'd1 << 5;
   localparam logic [19:0] LT1  = 20'd1 << 6;
   localparam logic [19:0] LV0  = 20'd1 << 7;
   localparam logic [19:0] LV1  = 20'd1 << 8;
   localparam logic [19:0] LDY0 = 20'd1 << 9;
   localparam logic [19:0] LDY1 = 20'd1 << 10;
   localparam logic [19:0] LLRU = 20'd1 << 11;
   localparam logic [19:0] V0I  = 20'd1 << 12;
   localparam logic [19:0] V1I  = 20'd1 << 13;
   localparam logic [19:0] D0I  = 20'd1 << 14;
   localparam logic [19:0] D1I  = 20'd1 << 15;
   localparam logic [19:0] LRUI = 20'd1 << 16;
   localparam logic [19:0] DMUX = 20'd1 << 17;
   localparam logic [19:0] AW0  = 20'd1 << 18;
   localparam logic [19:0] AW1  = 20'd2 << 18;

   localparam logic [19:0] FILL0 = PRD | LD0 | LT0 | LV0 | LDY0 | V0I;
   localparam logic [19:0] FILL1 = PRD | LD1 | LT1 | LV1 | LDY1 | V1I;

   typedef struct {
      logic [19:0] s;
      int          hc;
      int          mc;
      string       nm;
      bit          chk;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;
   bit   driver_done = 1'b0;

   logic [19:0] act;
   assign act = {addrmux_sel, datamux_sel, lru_in, dirty1_in, dirty0_in, valid1_in, valid0_in,
                 load_lru, load_dirty1, load_dirty0, load_valid1, load_valid0, load_tag1,
                 load_tag0, load_data1, load_data0, pmem_write, pmem_read, mem_resp};

   task automatic set_in(input logic r, input logic w, input logic h0, input logic h1,
                         input logic v0, input logic v1, input logic d0, input logic d1,
                         input logic lru, input logic presp);
      mem_read   = r;
      mem_write  = w;
      hit0       = h0;
      hit1       = h1;
      valid0_out = v0;
      valid1_out = v1;
      dirty0_out = d0;
      dirty1_out = d1;
      lru_out    = lru;
      pmem_resp  = presp;
   endtask

   // Push the expected response for the cycle whose inputs are now applied, then advance.
   task automatic step(input logic [19:0] s, input int hc, input int mc, input string nm,
                       input bit chk = 1'b1);
      exp_t e;
      e.s = s; e.hc = hc; e.mc = mc; e.nm = nm; e.chk = chk;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented cycle against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
               checks++;
               if (act === e.s) passed++;
               else $display("FAIL %s strobes: got %05h want %05h", e.nm, act, e.s);
               checks++;
               if (int'(hit_count) == e.hc && int'(miss_count) == e.mc) passed++;
               else $display("FAIL %s counters: got hit=%0d miss=%0d want hit=%0d miss=%0d",
                             e.nm, hit_count, miss_count, e.hc, e.mc);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      set_in(0,0,0,0,0,0,0,0,0,0);
      @(posedge clk);
      #1;
      step(20'd0, 0, 0, "reset");
      rst = 1'b0;

      // 1. read hit way1
      set_in(1,0,0,1,1,1,0,0,1,0);  step(RESP | LLRU, 0, 0, "rd_hit1");
      set_in(0,0,0,0,0,0,0,0,0,0);  step(20'd0, 1, 0, "idle1");

      // 2. write hit way0
      set_in(0,1,1,0,1,1,0,0,0,0);
      step(RESP | LLRU | LRUI | DMUX | LD0 | LDY0 | D0I, 1, 0, "wr_hit0");
      // both requests high behave as a write (way1)
      set_in(1,1,0,1,1,1,0,0,0,0);
      step(RESP | LLRU | DMUX | LD1 | LDY1 | D1I, 2, 0, "rw_hit1");
      set_in(0,0,0,0,0,0,0,0,0,0);  step(20'd0, 3, 0, "idle2");

      // 3. clean miss into way0, 4-cycle fill
      set_in(1,0,0,0,1,1,0,0,0,0);  step(20'd0, 3, 0, "clean_decide");
      for (int i = 0; i < 3; i++) step(PRD, 3, 1, "clean_fetch");
      set_in(1,0,0,0,1,1,0,0,0,1);  step(FILL0, 3, 1, "clean_fill");
      set_in(1,0,1,0,1,1,0,0,0,0);  step(RESP | LLRU | LRUI, 3, 1, "clean_hit");
      set_in(0,0,0,0,0,0,0,0,0,0);  step(20'd0, 4, 1, "idle3");

      // 4. dirty write miss, victim way1
      set_in(0,1,0,0,1,1,0,1,1,0);  step(20'd0, 4, 1, "dirty_decide");
      step(PWR | AW1, 4, 2, "dirty_wb");
      set_in(0,1,0,0,1,1,0,1,1,1);  step(PWR | AW1, 4, 2, "dirty_wb_resp");
      set_in(0,1,0,0,1,1,0,1,1,0);  step(PRD, 4, 2, "dirty_fetch");
      set_in(0,1,0,0,1,1,0,1,1,1);  step(FILL1, 4, 2, "dirty_fill");
      set_in(0,1,0,1,1,1,0,0,1,0);
      step(RESP | LLRU | DMUX | LD1 | LDY1 | D1I, 4, 2, "dirty_hit");
      set_in(0,0,0,0,0,0,0,0,0,0);  step(20'd0, 5, 2, "idle4");

      // 5. reset during FETCH; late pmem_resp ignored
      set_in(1,0,0,0,0,1,0,0,0,0);  step(20'd0, 5, 2, "rst_decide");
      step(PRD, 5, 3, "rst_fetch");
      rst = 1'b1;                   step(PRD, 5, 3, "rst_cycle", 1'b0);
      rst = 1'b0;
      set_in(0,0,0,0,0,0,0,0,0,1);  step(20'd0, 0, 0, "rst_late_resp");
      set_in(0,0,0,0,0,0,0,0,0,0);  step(20'd0, 0, 0, "rst_idle");

      // request dropped mid-miss: writeback of way0 then fill, no mem_resp
      set_in(1,0,0,0,1,1,1,0,0,0);  step(20'd0, 0, 0, "drop_decide");
      set_in(0,0,0,0,1,1,1,0,0,0);  step(PWR | AW0, 0, 1, "drop_wb");
      set_in(0,0,0,0,1,1,1,0,0,1);  step(PWR | AW0, 0, 1, "drop_wb_resp");
      set_in(0,0,0,0,1,1,1,0,0,0);  step(PRD, 0, 1, "drop_fetch");
      set_in(0,0,0,0,1,1,1,0,0,1);  step(FILL0, 0, 1, "drop_fill");
      set_in(0,0,0,0,0,0,0,0,0,0);  step(20'd0, 0, 1, "drop_idle");

      // 6. 20 held read hits saturate the 4-bit counter at 15
      set_in(1,0,1,0,1,1,0,0,1,0);
      for (int i = 0; i < 20; i++) step(RESP | LLRU | LRUI, (i > 15) ? 15 : i, 1, "sat_hit");
      set_in(0,0,0,0,0,0,0,0,0,0);  step(20'd0, 15, 1, "sat_final");

      repeat (2) @(posedge clk);
      checks++;
      if (q.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending want 0", q.size());
      driver_done = 1'b1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      if (!driver_done) begin
         $display("FAIL timeout: got no completion want completion");
         $fatal(1, "timeout");
      end
   end

endmodule
